// File: rtl/sample_uart_pkg.sv
// sample_uart_pkg: shared states and UART framing constants for the FIFO-to-UART sample dumper.
package sample_uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT = 1'b1;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser; o_ready also rises on the last stop-bit cycle so bytes chain with no gap.
module uart_tx_byte
  import sample_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       _mrst,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_sh;
  logic r_tx;
  logic w_tick;
  assign w_tick = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign o_ready = (r_state == IDLE) | ((r_state == STOP) & w_tick);
  assign o_tx = r_tx;
  always_ff @(posedge i_clk or negedge _mrst)
    if (!_mrst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh <= '0;
      r_tx <= UART_STOP_BIT;
    end else if (i_valid & o_ready) begin
      r_state <= START;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh <= i_byte;
      r_tx <= UART_START_BIT;
    end else if (r_state != IDLE) begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick)
        case (r_state)
          START: begin
            r_state <= DATA;
            r_tx <= r_sh[0];
          end
          DATA: begin
            r_sh <= r_sh >> 1;
            r_bit <= r_bit + 1'b1;
            r_state <= (r_bit == 3'd7) ? STOP : DATA;
            r_tx <= (r_bit == 3'd7) ? UART_STOP_BIT : r_sh[1];
          end
          default: r_state <= IDLE;
        endcase
    end
endmodule

// File: rtl/sample_uart_dumper.sv
// sample_uart_dumper: pops 32-bit FIFO words and sends them LSB byte first as 8N1 UART bytes.
// Define SAMPLE_UART_SYNC_EN to prefix every word with the sync byte A5.
module sample_uart_dumper
  import sample_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  _mrst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_q,
  output logic                  o_fifo_rdreq,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_word_done
);
`ifdef SAMPLE_UART_SYNC_EN
  localparam logic [2:0] LAST = 3'(BYTES_PER_WORD);
`else
  localparam logic [2:0] LAST = 3'(BYTES_PER_WORD - 1);
`endif
  state_t r_state;
  logic r_rdreq;
  logic [DATA_WIDTH-1:0] r_word;
  logic [2:0] r_idx;
  logic w_ready, w_valid;
  logic [7:0] w_byte;
  // DATA spans the whole byte stream; bit-level phases live in the serialiser.
  assign w_valid = (r_state == LATCH) | ((r_state == DATA) & (r_idx != LAST));
`ifdef SAMPLE_UART_SYNC_EN
  assign w_byte = (r_state == LATCH) ? SYNC_BYTE : r_word[{r_idx[1:0], 3'b000} +: 8];
`else
  logic [1:0] w_lane;
  assign w_lane = 2'(r_idx + 3'd1);
  assign w_byte = (r_state == LATCH) ? i_fifo_q[7:0] : r_word[{w_lane, 3'b000} +: 8];
`endif
  assign o_fifo_rdreq = r_rdreq;
  assign o_busy = r_state != IDLE;
  assign o_word_done = (r_state == DATA) & w_ready & (r_idx == LAST);
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk  (i_clk),
    ._mrst  (_mrst),
    .i_valid(w_valid),
    .i_byte (w_byte),
    .o_ready(w_ready),
    .o_tx   (o_tx)
  );
  always_ff @(posedge i_clk or negedge _mrst)
    if (!_mrst) begin
      r_state <= IDLE;
      r_rdreq <= 1'b0;
      r_word <= '0;
      r_idx <= '0;
    end else begin
      r_rdreq <= (r_state == IDLE) & i_enable & ~i_fifo_empty;
      case (r_state)
        IDLE: if (i_enable & ~i_fifo_empty) r_state <= POP;
        POP: r_state <= LATCH;
        LATCH: begin
          r_word <= i_fifo_q;
          r_idx <= '0;
          r_state <= DATA;
        end
        DATA: if (w_ready) begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sample_uart_dumper.sv
// tb_sample_uart_dumper: FIFO model feeds the dumper; a UART receiver decodes the line against a byte scoreboard.
module tb_sample_uart_dumper;
  localparam int CPB = 4;
`ifdef SAMPLE_UART_SYNC_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 4;
`endif
  localparam int WORD_CYC = BPW * 10 * CPB;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [31:0] fifo_q = '0;
  logic empty, rdreq, tx, busy, done;
  logic [31:0] mem [0:63];
  logic [7:0] exp_q [$];
  int wp = 0, rp = 0, total = 0, bad = 0, cyc = 0, n_pop = 0, n_done = 0, n_abort = 0;
  int wb = 0, fc = 0, ws = 0, rd_cyc = -100, done_cyc = -100;
  logic prev_rd = 1'b0, prev_busy = 1'b0;
  assign empty = (wp == rp);
  always #5 clk = ~clk;
  sample_uart_dumper #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(32)) dut (
    .i_clk       (clk),
    ._mrst       (rst_n),
    .i_enable    (en),
    .i_fifo_empty(empty),
    .i_fifo_q    (fifo_q),
    .o_fifo_rdreq(rdreq),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_word_done (done)
  );
  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic push(input logic [31:0] w);
    mem[wp] = w;
    wp++;
  endtask
  // Normal-mode FIFO: data appears the cycle after rdreq; the word's expected line bytes are queued then.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdreq && rp != wp) begin
      fifo_q <= mem[rp];
`ifdef SAMPLE_UART_SYNC_EN
      exp_q.push_back(8'hA5);
`endif
      for (int k = 0; k < 4; k++) exp_q.push_back(mem[rp][8*k +: 8]);
      rp <= rp + 1;
      n_pop++;
    end
  end
  always @(negedge clk) begin
    if (rdreq) begin
      chk("pop_nonempty", rp != wp, rp, wp);
      chk("pop_single", !prev_rd && !prev_busy, {prev_rd, prev_busy}, 0);
      rd_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_rd = rdreq;
    prev_busy = busy;
  end
  task automatic rx_frame(output logic ok, output logic [7:0] b);
    logic [9:0] f;
    bit glitch;
    ok = 1'b1;
    f = '0;
    glitch = 0;
    b = '0;
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (!rst_n) begin
          ok = 1'b0;
          return;
        end
        fc = i * CPB + c;
        if (c == 0) f[i] = tx;
        else if (tx !== f[i]) glitch = 1;
      end
    b = f[8:1];
    chk("frame", !glitch && f[0] == 1'b0 && f[9] == 1'b1, {glitch, f}, {1'b0, 1'b1, b, 1'b0});
    if (wb == BPW - 1) chk("done_at_end", done === 1'b1 && cyc - ws == WORD_CYC - 1, cyc - ws, WORD_CYC - 1);
    else chk("no_early_done", done === 1'b0, done, 0);
  endtask
  initial begin : rx
    logic ok;
    logic [7:0] b, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        wb = 0;
      end else if (tx === 1'b0) begin
        if (wb == 0) begin
          ws = cyc;
          chk("pop_to_start", cyc - rd_cyc == 2, cyc - rd_cyc, 2);
          chk("idle_gap", cyc - done_cyc >= 2, cyc - done_cyc, 2);
        end
        rx_frame(ok, b);
        if (!ok) begin
          exp_q.delete();
          wb = 0;
          n_abort++;
        end else if (exp_q.size() == 0) chk("unexpected_byte", 0, b, 0);
        else begin
          e = exp_q.pop_front();
          chk("byte", b == e, b, e);
          wb = (wb == BPW - 1) ? 0 : wb + 1;
        end
      end
    end
  end
  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (n_done < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done", n_done >= n, n_done, n);
  endtask
  task automatic wait_pos(input int b, input int f);
    int t = 0;
    while (!(wb == b && fc == f) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk("reach_pos", t < 3000, t, 3000);
  endtask
  initial begin
    int viol;
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx === 1'b1, tx, 1);
    chk("rst_outs", {rdreq, busy, done} === 3'b000, {rdreq, busy, done}, 0);
    rst_n = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || rdreq !== 1'b0) viol++;
    end
    chk("idle_empty", viol == 0, viol, 0);
    push(32'h12345678);
    wait_done(1, 400);
    push(32'hDEADBEEF);
    wait_done(2, 400);
    for (int i = 0; i < 3; i++) push($urandom);
    wait_done(5, 1000);
    push($urandom);
    push($urandom);
    wait_pos(1, CPB);
    @(negedge clk);
    en = 1'b0;
    wait_done(6, 400);
    repeat (60) @(negedge clk);
    chk("no_pop_disabled", wp - rp == 1 && busy === 1'b0, wp - rp, 1);
    en = 1'b1;
    wait_done(7, 400);
    push($urandom);
    push($urandom);
    wait_pos(2, 3 * CPB);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_tx", tx === 1'b1, tx, 1);
    chk("async_busy", busy === 1'b0, busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_done(8, 400);
    for (int i = 0; i < 6; i++) push($urandom);
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) en = ~en;
    end
    en = 1'b1;
    wait_done(14, 2000);
    repeat (20) @(negedge clk);
    chk("sb_empty", exp_q.size() == 0, exp_q.size(), 0);
    chk("all_popped", n_pop == wp, n_pop, wp);
    chk("done_count", n_done == n_pop - n_abort, n_done, n_pop - n_abort);
    chk("one_abort", n_abort == 1, n_abort, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
